serial_subtractor4b: RTL and testbench

SERIAL_SUBTRACTOR4B -- requirements
Module: serial_subtractor4b

---
 rtl/serial_subtractor4b.sv | 113 +++++++++++
 tb/tb_serial_subtractor4b.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor4b.sv
`default_nettype none
// ============================================================================
//  Module   : serial_subtractor4b
//  Purpose  : 4-bit subtractor built from one time-shared full-subtractor
//             cell. Bits are processed LSB first over four SHIFT cycles. The
//             registered result (DIFF, BORROW_OUT) loads on the last bit and
//             DONE pulses for one cycle afterwards.
//  Options  : define SERIAL_SUB_OVERFLOW_EN to add the OVERFLOW port and its
//             signed-overflow flag register.
//  Revision : 1.0 - initial release
// ============================================================================
module serial_subtractor4b (
  input  logic       CLK,
  input  logic       RST,
  input  logic       START,
  input  logic [3:0] X,
  input  logic [3:0] Y,
  input  logic       BORROW_IN,
  output logic [3:0] DIFF,
  output logic       BORROW_OUT,
  output logic       BUSY,
  output logic       DONE
`ifdef SERIAL_SUB_OVERFLOW_EN
  ,
  output logic       OVERFLOW
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FIN   = 2'd2
  } state_t;

  state_t     state;
  logic [3:0] x_reg;        // minuend captured at the accepting edge
  logic [3:0] y_reg;        // subtrahend captured at the accepting edge
  logic       borrow;       // running borrow into the bit being processed
  logic [1:0] bit_cnt;      // index of the bit being processed
  logic [2:0] diff_sh;      // completed low difference bits, newest at MSB

  logic       x_bit;
  logic       y_bit;
  logic       d_bit;
  logic       b_next;

  // Full-subtractor cell applied to the bit selected by the counter
  always_comb begin
    x_bit  = x_reg[bit_cnt];
    y_bit  = y_reg[bit_cnt];
    d_bit  = x_bit ^ y_bit ^ borrow;
    b_next = (~x_bit & y_bit) | (~(x_bit ^ y_bit) & borrow);
  end

  // Control FSM, operand capture, bit-serial datapath and registered outputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      bit_cnt    <= 2'd0;
      DIFF       <= 4'd0;
      BORROW_OUT <= 1'b0;
      BUSY       <= 1'b0;
      DONE       <= 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
      OVERFLOW   <= 1'b0;
`endif
    end else begin
      unique case (state)
        // FIN behaves like IDLE for acceptance so back-to-back runs lose no cycle
        IDLE, FIN: begin
          DONE <= 1'b0;
          if (START) begin
            x_reg   <= X;
            y_reg   <= Y;
            borrow  <= BORROW_IN;
            bit_cnt <= 2'd0;
            BUSY    <= 1'b1;
            state   <= SHIFT;
          end else begin
            BUSY  <= 1'b0;
            state <= IDLE;
          end
        end

        // START is deliberately not looked at here; operands stay frozen
        SHIFT: begin
          borrow  <= b_next;
          bit_cnt <= bit_cnt + 2'd1;   // wraps 3 -> 0 on the final bit
          diff_sh <= {d_bit, diff_sh[2:1]};
          if (bit_cnt == 2'd3) begin
            DIFF       <= {d_bit, diff_sh};
            BORROW_OUT <= b_next;
`ifdef SERIAL_SUB_OVERFLOW_EN
            // signed overflow: borrow into the sign bit differs from borrow out
            OVERFLOW   <= borrow ^ b_next;
`endif
            BUSY       <= 1'b0;
            DONE       <= 1'b1;
            state      <= FIN;
          end
        end

        default: begin
          BUSY  <= 1'b0;
          DONE  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor4b.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serial_subtractor4b
//  Purpose  : Scoreboard bench for serial_subtractor4b. A cycle-level protocol
//             model predicts accepted requests and pushes arithmetic results
//             into a queue; a negedge monitor pops and compares.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_serial_subtractor4b;

  logic       CLK = 1'b0;
  logic       RST;
  logic       START;
  logic [3:0] X;
  logic [3:0] Y;
  logic       BORROW_IN;
  logic [3:0] DIFF;
  logic       BORROW_OUT;
  logic       BUSY;
  logic       DONE;
`ifdef SERIAL_SUB_OVERFLOW_EN
  logic       OVERFLOW;
`endif

  serial_subtractor4b dut (
    .CLK        (CLK),
    .RST        (RST),
    .START      (START),
    .X          (X),
    .Y          (Y),
    .BORROW_IN  (BORROW_IN),
    .DIFF       (DIFF),
    .BORROW_OUT (BORROW_OUT),
    .BUSY       (BUSY),
    .DONE       (DONE)
`ifdef SERIAL_SUB_OVERFLOW_EN
    ,
    .OVERFLOW   (OVERFLOW)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int       done_cyc;
    logic [3:0] diff;
    logic     bout;
    logic     ovf;
  } exp_t;

  exp_t q[$];
  int   cyc         = 0;
  int   last_accept = -100;
  bit   chk_en      = 1'b0;
  int   errors      = 0;
  int   checks      = 0;
  int   n_done      = 0;
  logic [3:0] exp_diff = 4'd0;
  logic       exp_bout = 1'b0;
  logic       exp_ovf  = 1'b0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference model: plain integer arithmetic on the sampled operands
  function automatic exp_t compute(input int x, input int y, input int b, input int dc);
    exp_t e;
    int   sx, sy, sr;
    e.done_cyc = dc;
    e.diff     = 4'((x - y - b) & 15);
    e.bout     = (x < y + b);
    sx         = (x > 7) ? x - 16 : x;
    sy         = (y > 7) ? y - 16 : y;
    sr         = sx - sy - b;
    e.ovf      = (sr < -8) || (sr > 7);
    return e;
  endfunction

  // Protocol model: a request is taken once the previous one is 5 edges old
  always @(posedge CLK) begin
    cyc++;
    if (RST) begin
      chk_en      = 1'b1;
      q.delete();
      last_accept = -100;
      exp_diff    = 4'd0;
      exp_bout    = 1'b0;
      exp_ovf     = 1'b0;
    end else if (START && cyc >= last_accept + 5) begin
      last_accept = cyc;
      q.push_back(compute(int'(X), int'(Y), int'(BORROW_IN), cyc + 4));
    end
  end

  // Monitor: compare flags and result registers every cycle
  always @(negedge CLK) begin
    if (chk_en) begin
      bit exp_done;
      exp_t e;
      exp_done = 1'b0;
      if (q.size() > 0 && q[0].done_cyc == cyc) begin
        e        = q.pop_front();
        exp_done = 1'b1;
        exp_diff = e.diff;
        exp_bout = e.bout;
        exp_ovf  = e.ovf;
        n_done++;
      end
      chk("DONE", int'(DONE), int'(exp_done));
      chk("BUSY", int'(BUSY), int'(cyc >= last_accept && cyc <= last_accept + 3));
      chk("DIFF", int'(DIFF), int'(exp_diff));
      chk("BORROW_OUT", int'(BORROW_OUT), int'(exp_bout));
`ifdef SERIAL_SUB_OVERFLOW_EN
      chk("OVERFLOW", int'(OVERFLOW), int'(exp_ovf));
`endif
    end
  end

  // Apply one cycle of inputs, then advance past the next rising edge
  task automatic drive(input bit s, input int x, input int y, input bit b, input bit r);
    START     = s;
    X         = 4'(x);
    Y         = 4'(y);
    BORROW_IN = b;
    RST       = r;
    @(posedge CLK);
    #1;
  endtask

  task automatic op(input int x, input int y, input bit b, input int idle_after);
    drive(1'b1, x, y, b, 1'b0);
    for (int i = 0; i < idle_after; i++)
      drive(1'b0, $urandom_range(15), $urandom_range(15), 1'($urandom_range(1)), 1'b0);
  endtask

  initial begin
    drive(1'b0, 0, 0, 1'b0, 1'b1);
    drive(1'b1, 9, 3, 1'b0, 1'b1);   // reset overrides START
    drive(1'b0, 0, 0, 1'b0, 1'b0);

    op(9, 3, 1'b0, 6);
    op(3, 9, 1'b0, 6);
    op(0, 0, 1'b1, 6);
    op(8, 1, 1'b0, 6);
    op(6, 2, 1'b0, 6);

    // START held high; operands scrambled except on accepting edges
    for (int i = 0; i < 20; i++) begin
      if (cyc + 1 >= last_accept + 5)
        drive(1'b1, 7, 2, 1'b0, 1'b0);
      else
        drive(1'b1, $urandom_range(15), $urandom_range(15), 1'($urandom_range(1)), 1'b0);
    end
    drive(1'b0, 0, 0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) drive(1'b0, 0, 0, 1'b0, 1'b0);

    // reset two cycles after START abandons the operation
    drive(1'b1, 5, 1, 1'b0, 1'b0);
    drive(1'b0, 5, 1, 1'b0, 1'b0);
    drive(1'b0, 5, 1, 1'b0, 1'b1);
    drive(1'b0, 0, 0, 1'b0, 1'b0);
    op(5, 1, 1'b0, 6);

    // randomized traffic with occasional resets
    for (int i = 0; i < 1500; i++)
      drive(1'($urandom_range(1)), $urandom_range(15), $urandom_range(15),
            1'($urandom_range(1)), ($urandom_range(39) == 0));
    for (int i = 0; i < 8; i++) drive(1'b0, 0, 0, 1'b0, 1'b0);

    chk("queue_drained", q.size(), 0);
    chk("results_seen", int'(n_done > 20), 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
